// File: rtl/decode_pkg.sv
// Shared decode-stage types and constants: the uop record, fetch epoch width
// and the default depth of the decode-to-rename uop buffer.
package decode_pkg;

  localparam int FETCH_EPOCH_W = 3;
  localparam int UOPBUF_DEPTH  = 16;

  typedef struct packed {
    logic                     valid;
    logic [FETCH_EPOCH_W-1:0] fetch_epoch;
    logic [31:0]              pc;
    logic [7:0]               opcode;
  } uop_t;

endpackage

// File: rtl/uop_enq_compact.sv
// Lane compaction for the uop buffer enqueue side: an exclusive prefix count
// of accepted lanes gives each lane its slot offset from tail, and the total
// gives the tail advance.
module uop_enq_compact #(
  parameter  int ENQ_W = 4,
  localparam int OW    = $clog2(ENQ_W + 1)
) (
  input  logic [ENQ_W-1:0]         accept_i,
  output logic [ENQ_W-1:0][OW-1:0] offset_o,
  output logic [OW-1:0]            n_enq_o
);

  logic [OW-1:0] run;

  // Running count of accepted lanes below each lane.
  always_comb begin
    // NOTE: blocking assignments here are deliberate; 'run' is a ripple sum
    // that must update within the loop iteration, not a register.
    run = '0;
    for (int i = 0; i < ENQ_W; i++) begin
      offset_o[i] = run;
      run         = run + OW'(accept_i[i]);
    end
    n_enq_o = run;
  end

endmodule

// File: rtl/decode_uop_buffer.sv
// Decode-to-rename uop buffer: circular buffer accepting up to ENQ_W sparse
// lanes per cycle (compacted in order) and presenting the oldest DEQ_W uops
// as a contiguous valid prefix. DEPTH must be a power of two and at least
// max(ENQ_W, DEQ_W).
// Optional feature: define UOP_BUF_EPOCH_FILTER_EN to drop incoming uops whose
// fetch_epoch differs from the epoch loaded on the most recent flush.
module decode_uop_buffer
  import decode_pkg::*;
#(
  parameter int DEPTH = UOPBUF_DEPTH,
  parameter int ENQ_W = 4,
  parameter int DEQ_W = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [FETCH_EPOCH_W-1:0]     flush_epoch_i,
  input  logic [ENQ_W-1:0]             enq_valid_i,
  input  uop_t [ENQ_W-1:0]             enq_uop_i,
  output logic                         enq_ready_o,
  output logic [DEQ_W-1:0]             deq_valid_o,
  output uop_t [DEQ_W-1:0]             deq_uop_o,
  input  logic [DEQ_W-1:0]             deq_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(ENQ_W + 1);
  localparam int DW = $clog2(DEQ_W + 1);

  // Pointers carry one extra wrap bit above the index.
  logic [PW:0]             head_q;
  logic [PW:0]             tail_q;
  uop_t                    mem [DEPTH];

  logic                    full;
  logic                    do_enq;
  logic [ENQ_W-1:0]        accept;
  logic [ENQ_W-1:0][OW-1:0] offset;
  logic [OW-1:0]           n_enq;
  logic [DW-1:0]           n_deq;
  logic                    run_ok;

  // Occupancy follows from the pointer difference; with a power-of-two depth
  // the wrap bit makes the subtraction range 0..DEPTH.
  assign count_o = CW'(tail_q - head_q);
  assign full    = (head_q[PW-1:0] == tail_q[PW-1:0]) && (head_q[PW] != tail_q[PW]);

  // Ready depends only on registered pointers, so the consumer's ready cannot
  // ripple back into the decode side in the same cycle.
  assign enq_ready_o = !full && (count_o <= CW'(DEPTH - ENQ_W));
  assign do_enq      = enq_ready_o && !flush_i;

`ifdef UOP_BUF_EPOCH_FILTER_EN
  logic [FETCH_EPOCH_W-1:0] cur_epoch;

  // Epoch register: cleared on reset, reloaded from the flush request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_epoch <= '0;
    end else if (flush_i) begin
      cur_epoch <= flush_epoch_i;
    end
  end

  // Lanes from a stale fetch epoch are dropped before compaction.
  always_comb begin
    for (int i = 0; i < ENQ_W; i++) begin
      accept[i] = enq_valid_i[i] && (enq_uop_i[i].fetch_epoch == cur_epoch);
    end
  end
`else
  logic unused_flush_epoch;
  assign unused_flush_epoch = ^flush_epoch_i;
  assign accept             = enq_valid_i;
`endif

  uop_enq_compact #(.ENQ_W(ENQ_W)) u_compact (
    .accept_i (accept),
    .offset_o (offset),
    .n_enq_o  (n_enq)
  );

  // Dequeue count: leading run of valid-and-ready lanes, stopping at the first gap.
  always_comb begin
    n_deq  = '0;
    run_ok = 1'b1;
    for (int i = 0; i < DEQ_W; i++) begin
      if (run_ok && deq_valid_o[i] && deq_ready_i[i]) begin
        n_deq = n_deq + DW'(1);
      end else begin
        run_ok = 1'b0;
      end
    end
  end

  // Read port: lane i shows the entry at head+i, wrapping modulo DEPTH.
  always_comb begin
    for (int i = 0; i < DEQ_W; i++) begin
      deq_valid_o[i]     = (count_o > CW'(i));
      deq_uop_o[i]       = mem[PW'(head_q[PW-1:0] + PW'(i))];
      deq_uop_o[i].valid = mem[PW'(head_q[PW-1:0] + PW'(i))].valid && deq_valid_o[i];
    end
  end

  // Pointer update: reset, then flush, then the enqueue/dequeue handshakes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (flush_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (do_enq) begin
        tail_q <= tail_q + (PW+1)'(n_enq);
      end
      head_q <= head_q + (PW+1)'(n_deq);
    end
  end

  // Entry storage: accepted lanes land in consecutive slots starting at tail.
  always_ff @(posedge clk_i) begin
    // NOTE: the entry array has no reset; deq_valid_o masks stale contents,
    // and leaving it out keeps the storage a plain register file.
    if (!rst_i && do_enq) begin
      for (int i = 0; i < ENQ_W; i++) begin
        if (accept[i]) begin
          mem[PW'(tail_q[PW-1:0] + PW'(offset[i]))] <= enq_uop_i[i];
        end
      end
    end
  end

endmodule
